// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit memory port.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        SPLIT = 2'd3
    } lsu_state_t;

    typedef logic [1:0] xfer_log2_t;

    localparam int unsigned LSU_MEM_SIZE_DEFAULT = 1024;

    // Transfer size in bytes from its log2 encoding.
    function automatic logic [3:0] size_bytes(input xfer_log2_t sz);
        logic [3:0] b;
        case (sz)
            2'd0:    b = 4'd1;
            2'd1:    b = 4'd2;
            2'd2:    b = 4'd4;
            default: b = 4'd8;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lsu_mem_port_load_extend.sv
// load_extend: sign/zero-extends the low bytes of raw load data to 64 bits.
module load_extend (
    input  logic [63:0] raw_data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [63:0] ext_data_c
);

    // Keep the transfer-sized low bytes, fill the rest with sign or zero.
    always_comb begin
        ext_data_c = raw_data;
        case (size)
            2'd0:    ext_data_c = {{56{sign_ext & raw_data[7]}},  raw_data[7:0]};
            2'd1:    ext_data_c = {{48{sign_ext & raw_data[15]}}, raw_data[15:0]};
            2'd2:    ext_data_c = {{32{sign_ext & raw_data[31]}}, raw_data[31:0]};
            default: ext_data_c = raw_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit initiator port to a byte-addressed, little-endian data memory.
// Build option LSU_MISALIGN_SPLIT_EN: misaligned in-bounds accesses run as byte-wide sequences
// instead of returning an error.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = LSU_MEM_SIZE_DEFAULT,
    parameter int unsigned ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] addr,
    output logic [63:0]       writeData,
    output logic              writeEnable,
    output logic              readEnable,
    output logic [3:0]        xferSize,
    input  logic [63:0]       readData
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CHK_W  = ADDR_W + 1;

    lsu_state_t        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              write_enable_q, write_enable_d;
    logic              read_enable_q, read_enable_d;
    logic [3:0]        xfer_size_q, xfer_size_d;
    logic [1:0]        lat_size_q, lat_size_d;
    logic              lat_signed_q, lat_signed_d;

    logic [3:0]        req_bytes_c;
    logic              misalign_c;
    logic              oob_c;
    logic              req_err_c;
    logic [DATA_W-1:0] ext_raw_c;
    logic [DATA_W-1:0] ext_data_c;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              lat_write_q, lat_write_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        cnt_nx_c;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [3:0]        lat_bytes_c;
`endif

    // Request legality: alignment, and bounds evaluated one bit wider so the sum cannot wrap.
    always_comb begin
        req_bytes_c = size_bytes(req_size);
        misalign_c  = (req_addr & ADDR_W'(req_bytes_c - 4'd1)) != '0;
        oob_c       = (CHK_W'(req_addr) + CHK_W'(req_bytes_c)) > CHK_W'(MEM_SIZE);
`ifdef LSU_MISALIGN_SPLIT_EN
        req_err_c   = oob_c;
`else
        req_err_c   = oob_c | misalign_c;
`endif
    end

    // Raw load data: straight from memory, or the byte-assembled value on the last split beat.
`ifdef LSU_MISALIGN_SPLIT_EN
    assign lat_bytes_c = size_bytes(lat_size_q);
    assign cnt_nx_c    = cnt_q + 3'd1;
    assign ext_raw_c   = (state_q == SPLIT)
                       ? (asm_q | (DATA_W'(readData[7:0]) << {cnt_q, 3'b000}))
                       : readData;
`else
    assign ext_raw_c   = readData;
`endif

    load_extend u_load_extend (
        .raw_data   (ext_raw_c),
        .size       (lat_size_q),
        .sign_ext   (lat_signed_q),
        .ext_data_c (ext_data_c)
    );

    // Next-state and next-output logic; memory outputs default to their idle values.
    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        resp_valid_d   = resp_valid_q;
        resp_err_d     = resp_err_q;
        resp_rdata_d   = resp_rdata_q;
        addr_d         = '0;
        write_data_d   = '0;
        write_enable_d = 1'b0;
        read_enable_d  = 1'b0;
        xfer_size_d    = 4'd8;
        lat_size_d     = lat_size_q;
        lat_signed_d   = lat_signed_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        lat_write_d    = lat_write_q;
        lat_addr_d     = lat_addr_q;
        lat_wdata_d    = lat_wdata_q;
        cnt_d          = cnt_q;
        asm_d          = asm_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d  = 1'b0;
                    lat_size_d   = req_size;
                    lat_signed_d = req_signed;
`ifdef LSU_MISALIGN_SPLIT_EN
                    lat_write_d  = req_write;
                    lat_addr_d   = req_addr;
                    lat_wdata_d  = req_wdata;
`endif
                    if (req_err_c) begin
                        // resp_valid rises one cycle later, matching the legal-access latency
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
`ifdef LSU_MISALIGN_SPLIT_EN
                    else if (misalign_c) begin
                        state_d        = SPLIT;
                        cnt_d          = 3'd0;
                        asm_d          = '0;
                        addr_d         = req_addr;
                        xfer_size_d    = 4'd1;
                        write_enable_d = req_write;
                        read_enable_d  = ~req_write;
                        write_data_d   = req_write ? DATA_W'(req_wdata[7:0]) : '0;
                    end
`endif
                    else begin
                        state_d        = ISSUE;
                        addr_d         = req_addr;
                        xfer_size_d    = req_bytes_c;
                        write_enable_d = req_write;
                        read_enable_d  = ~req_write;
                        write_data_d   = req_write ? req_wdata : '0;
                    end
                end
            end
            ISSUE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = read_enable_q ? ext_data_c : '0;
            end
            RESP: begin
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                    req_ready_d  = 1'b1;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                if (cnt_q == 3'(lat_bytes_c - 4'd1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = lat_write_q ? '0 : ext_data_c;
                end else begin
                    cnt_d          = cnt_nx_c;
                    asm_d          = ext_raw_c;
                    addr_d         = lat_addr_q + ADDR_W'(cnt_nx_c);
                    xfer_size_d    = 4'd1;
                    write_enable_d = lat_write_q;
                    read_enable_d  = ~lat_write_q;
                    write_data_d   = lat_write_q
                                   ? DATA_W'(8'(lat_wdata_q >> {cnt_nx_c, 3'b000}))
                                   : '0;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops strobes immediately and discards the held request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= '0;
            addr_q         <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            xfer_size_q    <= 4'd8;
            lat_size_q     <= 2'd0;
            lat_signed_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_rdata_q   <= resp_rdata_d;
            addr_q         <= addr_d;
            write_data_q   <= write_data_d;
            write_enable_q <= write_enable_d;
            read_enable_q  <= read_enable_d;
            xfer_size_q    <= xfer_size_d;
            lat_size_q     <= lat_size_d;
            lat_signed_q   <= lat_signed_d;
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Split-sequence registers: held request, byte counter and load assembly buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            cnt_q       <= 3'd0;
            asm_q       <= '0;
        end else begin
            lat_write_q <= lat_write_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
        end
    end
`endif

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign addr        = addr_q;
    assign writeData   = write_data_q;
    assign writeEnable = write_enable_q;
    assign readEnable  = read_enable_q;
    assign xferSize    = xfer_size_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed self-checking bench for lsu_mem_port with a byte-array memory model.
module tb_lsu_mem_port;

    localparam int unsigned MEM_SIZE = 1024;
    localparam int unsigned ADDR_W   = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       writeData;
    logic              writeEnable;
    logic              readEnable;
    logic [3:0]        xferSize;
    logic [63:0]       readData;

    logic [7:0] mem [0:MEM_SIZE-1];
    logic       mem_init;
    int         errors = 0;
    int         checks = 0;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         both_cnt = 0;
    logic [3:0] we_size = 4'd0;

    always #5 clk = ~clk;

    lsu_mem_port #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .addr        (addr),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .readEnable  (readEnable),
        .xferSize    (xferSize),
        .readData    (readData)
    );

    // Combinational memory read
    always_comb begin
        readData = '0;
        for (int i = 0; i < 8; i++)
            if (i < int'(xferSize))
                readData[8*i +: 8] = mem[(int'(addr[9:0]) + i) & 1023];
    end

    // Memory write, initial fill and strobe monitors
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] <= 8'(i * 7 + 3);
        end else if (writeEnable) begin
            for (int i = 0; i < 8; i++)
                if (i < int'(xferSize))
                    mem[(int'(addr[9:0]) + i) & 1023] <= writeData[8*i +: 8];
        end
        if (writeEnable) begin we_cnt = we_cnt + 1; we_size = xferSize; end
        if (readEnable) re_cnt = re_cnt + 1;
        if (writeEnable && readEnable) both_cnt = both_cnt + 1;
    end

    // One request/response; called #1 after an edge with the unit idle.
    task automatic do_txn(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                          input logic [1:0] sz, input logic sg,
                          output logic [63:0] rd, output logic er, output int lat);
        req_write = wr; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rd = resp_rdata; er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_signed = 1'b0; resp_ready = 1'b0;
        @(posedge clk); #1;
        mem_init = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
        checks++; if (addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
        checks++; if (writeData !== 64'h0) begin errors++; $display("FAIL reset_writeData: got %h want 0", writeData); end
        checks++; if ({writeEnable, readEnable} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {writeEnable, readEnable}); end
        checks++; if (xferSize !== 4'd8) begin errors++; $display("FAIL reset_xferSize: got %0d want 8", xferSize); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [63:0] rd; logic er; int lat; int we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        do_txn(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 64'h0) begin errors++; $display("FAIL store8_resp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL store8_latency: got %0d want 1", lat); end
        checks++; if (we_cnt - we0 !== 1 || re_cnt - re0 !== 0) begin errors++; $display("FAIL store8_strobes: got we=%0d re=%0d want we=1 re=0", we_cnt - we0, re_cnt - re0); end
        checks++; if (we_size !== 4'd8) begin errors++; $display("FAIL store8_xferSize: got %0d want 8", we_size); end
        re0 = re_cnt;
        do_txn(1'b0, 64'h10, 64'h0, 2'd3, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 64'h1122334455667788) begin errors++; $display("FAIL load8: got err=%b rdata=%h want err=0 rdata=1122334455667788", er, rd); end
        checks++; if (re_cnt - re0 !== 1) begin errors++; $display("FAIL load8_strobes: got re=%0d want 1", re_cnt - re0); end
    endtask

    task automatic test_sign_ext();
        logic [63:0] rd; logic er; int lat;
        do_txn(1'b0, 64'h17, 64'h0, 2'd0, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'h11) begin errors++; $display("FAIL lb_pos: got %h want 11", rd); end
        do_txn(1'b0, 64'h10, 64'h0, 2'd0, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL lb_neg: got %h want ffffffffffffff88", rd); end
        do_txn(1'b0, 64'h10, 64'h0, 2'd0, 1'b0, rd, er, lat);
        checks++; if (rd !== 64'h88) begin errors++; $display("FAIL lbu: got %h want 88", rd); end
        do_txn(1'b1, 64'h20, 64'hFEDCBA9876543210, 2'd3, 1'b0, rd, er, lat);
        do_txn(1'b0, 64'h26, 64'h0, 2'd1, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'hFFFFFFFFFFFFFEDC) begin errors++; $display("FAIL lh_neg: got %h want fffffffffffffedc", rd); end
        do_txn(1'b0, 64'h24, 64'h0, 2'd2, 1'b1, rd, er, lat);
        checks++; if (rd !== 64'hFFFFFFFFFEDCBA98) begin errors++; $display("FAIL lw_neg: got %h want fffffffffedcba98", rd); end
        do_txn(1'b0, 64'h24, 64'h0, 2'd2, 1'b0, rd, er, lat);
        checks++; if (rd !== 64'h00000000FEDCBA98) begin errors++; $display("FAIL lwu: got %h want 00000000fedcba98", rd); end
    endtask

    task automatic test_misalign();
        logic [63:0] rd; logic er; int lat; int we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        do_txn(1'b0, 64'h12, 64'h0, 2'd2, 1'b0, rd, er, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (er !== 1'b0 || rd !== 64'h33445566) begin errors++; $display("FAIL misalign_split: got err=%b rdata=%h want err=0 rdata=33445566", er, rd); end
        checks++; if (re_cnt - re0 !== 4 || we_cnt - we0 !== 0) begin errors++; $display("FAIL misalign_split_strobes: got re=%0d we=%0d want re=4 we=0", re_cnt - re0, we_cnt - we0); end
`else
        checks++; if (er !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL misalign_err: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
        checks++; if (re_cnt - re0 !== 0 || we_cnt - we0 !== 0) begin errors++; $display("FAIL misalign_strobes: got re=%0d we=%0d want 0 0", re_cnt - re0, we_cnt - we0); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL misalign_latency: got %0d want 1", lat); end
`endif
    endtask

    task automatic test_bounds();
        logic [63:0] rd; logic er; int lat; int we0;
        we0 = we_cnt;
        do_txn(1'b1, 64'h3F8, 64'h0123456789ABCDEF, 2'd3, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0 || we_cnt - we0 !== 1) begin errors++; $display("FAIL store_top: got err=%b we=%0d want err=0 we=1", er, we_cnt - we0); end
        we0 = we_cnt;
        do_txn(1'b1, 64'h400, 64'hAAAAAAAAAAAAAAAA, 2'd3, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 64'h0 || we_cnt - we0 !== 0) begin errors++; $display("FAIL store_oob: got err=%b rdata=%h we=%0d want err=1 rdata=0 we=0", er, rd, we_cnt - we0); end
        do_txn(1'b0, 64'h3F8, 64'h0, 2'd3, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL readback_top: got err=%b rdata=%h want err=0 rdata=0123456789abcdef", er, rd); end
        do_txn(1'b0, 64'h3FF, 64'h0, 2'd0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 64'h01) begin errors++; $display("FAIL load_last_byte: got err=%b rdata=%h want err=0 rdata=01", er, rd); end
        do_txn(1'b0, 64'h400, 64'h0, 2'd0, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL load_oob_byte: got err=%b want 1", er); end
        do_txn(1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 2'd3, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL load_wrap: got err=%b want 1", er); end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd; logic er; int lat;
        req_write = 1'b0; req_addr = 64'h10; req_size = 2'd3; req_signed = 1'b0;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_arrive: got %b want 1", resp_valid); end
        req_addr = 64'h17; req_size = 2'd0; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122334455667788 || resp_err !== 1'b0 ||
                req_ready !== 1'b0 || readEnable !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b re=%b want 1 1122334455667788 0 0 0",
                         c, resp_valid, resp_rdata, resp_err, req_ready, readEnable);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || readEnable !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b re=%b want 0 1 0", resp_valid, req_ready, readEnable); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (readEnable !== 1'b1 || xferSize !== 4'd1 || addr !== 64'h17) begin errors++; $display("FAIL bp_next_issue: got re=%b size=%0d addr=%h want 1 1 17", readEnable, xferSize, addr); end
        lat = 0;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rd = resp_rdata; er = resp_err;
        checks++; if (rd !== 64'h11 || er !== 1'b0) begin errors++; $display("FAIL bp_next_data: got rdata=%h err=%b want 11 0", rd, er); end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_during_issue();
        logic [63:0] rd; logic er; int lat; int we0;
        req_write = 1'b1; req_addr = 64'h30; req_wdata = 64'hDEADBEEFCAFEF00D;
        req_size = 2'd3; req_signed = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (writeEnable !== 1'b1) begin errors++; $display("FAIL rst_issue_we: got %b want 1", writeEnable); end
        we0 = we_cnt;
        #2 reset = 1'b1;
        #1;
        checks++; if (writeEnable !== 1'b0 || readEnable !== 1'b0 || addr !== 64'h0) begin errors++; $display("FAIL rst_async_strobes: got we=%b re=%b addr=%h want 0 0 0", writeEnable, readEnable, addr); end
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_async_idle: got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL rst_no_write: got we=%0d want 0", we_cnt - we0); end
        do_txn(1'b0, 64'h30, 64'h0, 2'd3, 1'b0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 64'h847D766F68615A53) begin errors++; $display("FAIL rst_readback: got err=%b rdata=%h want err=0 rdata=847d766f68615a53", er, rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_sign_ext();
        test_misalign();
        test_bounds();
        test_backpressure();
        test_reset_during_issue();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL both_strobes: got %0d cycles want 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
